// File: rtl/ip_vlg_pkg.sv
// Shared types and default constants for the IPv4 transmit arbiter.
// Also holds the width helpers used to size index and counter registers.
package ip_vlg_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACTIVE = 2'd1,
        ST_GAP    = 2'd2
    } arb_state_e;

    localparam int DEF_N             = 3;
    localparam int DEF_PRIO0         = 1;
    localparam int DEF_TIMEOUT_TICKS = 10000;
    localparam int DEF_GAP_TICKS     = 12;

    // Index width that stays at least one bit when there is a single requester
    function automatic int idx_width(input int n);
        if (n > 1) begin
            return $clog2(n);
        end else begin
            return 1;
        end
    endfunction

    function automatic int cnt_width(input int ticks);
        if (ticks > 0) begin
            return $clog2(ticks + 1);
        end else begin
            return 1;
        end
    endfunction

endpackage

// File: rtl/ipv4_tx_rr.sv
// Combinational winner selection: optional strict priority for requester 0,
// otherwise round-robin starting one past the last winner.
module ipv4_tx_rr
    import ip_vlg_pkg::*;
#(
    parameter int N     = DEF_N,
    parameter int PRIO0 = DEF_PRIO0
) (
    input  logic [N-1:0]              req,
    input  logic [idx_width(N)-1:0]   last,
    output logic [N-1:0]              win_oh,
    output logic [idx_width(N)-1:0]   win_idx,
    output logic                      win_any
);

    localparam int SW = idx_width(N);

    int best_s;

    // Smallest rotated distance from last+1 among active requests wins
    always_comb begin
        best_s  = N;
        win_idx = '0;
        win_oh  = '0;
        if ((PRIO0 != 32'sd0) && req[0]) begin
            best_s  = 32'sd0;
            win_idx = '0;
        end else begin
            for (int i = 0; i < N; i++) begin
                if (req[i] && (((i + N - 32'sd1 - int'(last)) % N) < best_s)) begin
                    best_s  = (i + N - 32'sd1 - int'(last)) % N;
                    win_idx = SW'(i);
                end else begin
                    best_s  = best_s;
                    win_idx = win_idx;
                end
            end
        end
        win_any = (best_s < N);
        for (int i = 0; i < N; i++) begin
            win_oh[i] = win_any && (win_idx == SW'(i));
        end
    end

endmodule

// File: rtl/ipv4_tx_arb.sv
// IPv4 TX arbiter: grants one requester per frame, enforces an inter-frame gap
// and a per-frame timeout. Frame-end pulses appear the cycle after the ending ACTIVE cycle.
module ipv4_tx_arb
    import ip_vlg_pkg::*;
#(
    parameter int N             = DEF_N,
    parameter int PRIO0         = DEF_PRIO0,
    parameter int TIMEOUT_TICKS = DEF_TIMEOUT_TICKS,
    parameter int GAP_TICKS     = DEF_GAP_TICKS
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [N-1:0]            req,
    output logic [N-1:0]            gnt,
    output logic [idx_width(N)-1:0] sel,
    output logic [N-1:0]            done,
    output logic [N-1:0]            err,
    output logic [N-1:0]            flush,
    input  logic                    tx_rdy,
    output logic                    tx_start,
    input  logic                    tx_eof
);

    localparam int SW = idx_width(N);
    localparam int CW = cnt_width(TIMEOUT_TICKS);
    localparam int GW = cnt_width(GAP_TICKS);
    // Last pointer resets to N-1 so the first search begins at index 0
    localparam logic [SW-1:0] LAST_RST = SW'(N - 1);

    arb_state_e      state_r, state_s;
    logic            armed_r;
    logic [SW-1:0]   last_r, sel_r;
    logic [CW-1:0]   cnt_r;
    logic [GW-1:0]   gap_r;
    logic [N-1:0]    gnt_r, done_r, err_r, flush_r;
    logic            tx_start_r;
    logic [N-1:0]    gnt_s, done_s, err_s, flush_s;
    logic            tx_start_s;
    logic [N-1:0]    win_oh_s;
    logic [SW-1:0]   win_idx_s;
    logic            win_any_s;
    logic            grant_s, eof_s, tmo_s, gap_end_s;

    ipv4_tx_rr #(
        .N     (N),
        .PRIO0 (PRIO0)
    ) u_rr (
        .req     (req),
        .last    (last_r),
        .win_oh  (win_oh_s),
        .win_idx (win_idx_s),
        .win_any (win_any_s)
    );

    // armed_r blocks arbitration in the first cycle after reset release
    assign grant_s   = (state_r == ST_IDLE) && armed_r && tx_rdy && win_any_s;
    assign eof_s     = (state_r == ST_ACTIVE) && tx_eof;
    assign tmo_s     = (state_r == ST_ACTIVE) && ((int'(cnt_r) + 32'sd1) >= TIMEOUT_TICKS);
    assign gap_end_s = (state_r == ST_GAP) && ((int'(gap_r) + 32'sd1) >= GAP_TICKS);

    // State register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Next-state decode
    always_comb begin
        state_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (grant_s) state_s = ST_ACTIVE;
                else         state_s = ST_IDLE;
            end
            ST_ACTIVE: begin
                if (eof_s || tmo_s) state_s = ST_GAP;
                else                state_s = ST_ACTIVE;
            end
            ST_GAP: begin
                if (gap_end_s) state_s = ST_IDLE;
                else           state_s = ST_GAP;
            end
            default: state_s = ST_IDLE;
        endcase
    end

    // Next values of the registered outputs; eof takes precedence over timeout
    always_comb begin
        gnt_s      = '0;
        done_s     = '0;
        err_s      = '0;
        flush_s    = '0;
        tx_start_s = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (grant_s) begin
                    gnt_s      = win_oh_s;
                    tx_start_s = 1'b1;
                end else begin
                    gnt_s = '0;
                end
            end
            ST_ACTIVE: begin
                if (eof_s) begin
                    done_s  = gnt_r;
                    flush_s = gnt_r;
                end else if (tmo_s) begin
                    err_s   = gnt_r;
                    flush_s = gnt_r;
                end else begin
                    gnt_s = gnt_r;
                end
            end
            ST_GAP:  gnt_s = '0;
            default: gnt_s = '0;
        endcase
    end

    // Output registers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            gnt_r      <= '0;
            done_r     <= '0;
            err_r      <= '0;
            flush_r    <= '0;
            tx_start_r <= 1'b0;
        end else begin
            gnt_r      <= gnt_s;
            done_r     <= done_s;
            err_r      <= err_s;
            flush_r    <= flush_s;
            tx_start_r <= tx_start_s;
        end
    end

    // Winner pointers, timeout counter and gap counter
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            armed_r <= 1'b0;
            last_r  <= LAST_RST;
            sel_r   <= '0;
            cnt_r   <= '0;
            gap_r   <= '0;
        end else begin
            armed_r <= 1'b1;
            if (grant_s) begin
                last_r <= win_idx_s;
                sel_r  <= win_idx_s;
                cnt_r  <= '0;
            end else if ((state_r == ST_ACTIVE) && (cnt_r != {CW{1'b1}})) begin
                cnt_r  <= cnt_r + 1'b1;
            end else begin
                cnt_r  <= cnt_r;
            end
            if (state_r == ST_ACTIVE) begin
                gap_r <= '0;
            end else if ((state_r == ST_GAP) && (gap_r != {GW{1'b1}})) begin
                gap_r <= gap_r + 1'b1;
            end else begin
                gap_r <= gap_r;
            end
        end
    end

    assign gnt      = gnt_r;
    assign sel      = sel_r;
    assign done     = done_r;
    assign err      = err_r;
    assign flush    = flush_r;
    assign tx_start = tx_start_r;

endmodule
